// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: access sizes, FSM states,
// requester ids and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Size 3 is never legal; halves need an even address, words a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane datapath: load extraction with sign/zero extension, sub-word store
// merge into a full word, and misalignment detection.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Little-endian lane select for loads and read-modify-write merge for stores
    always_comb begin
        load_o       = 32'd0;
        merge_o      = rdata_i;
        misaligned_o = is_misaligned(size_i, addr_lo_i);
        case (size_i)
            SZ_B: begin
                load_o = {{24{~unsigned_i & byte_s[7]}}, byte_s};
                merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_H: begin
                load_o = {{16{~unsigned_i & half_s[15]}}, half_s};
                if (addr_lo_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            SZ_W: begin
                load_o  = rdata_i;
                merge_o = wdata_i;
            end
            default: begin
                load_o  = 32'd0;
                merge_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the fetch
// and load/store ports; sub-word stores are done as read-modify-write.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    state_t              state_q, state_d;
    port_t               last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
    logic [31:0]         rmw_wdata_q, rmw_wdata_d;
    logic                i_rvalid_q, i_rvalid_d;
    logic [31:0]         i_rdata_q, i_rdata_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic                d_err_q, d_err_d;

    logic [31:0]         load_s;
    logic [31:0]         merge_s;
    logic                mis_s;
    logic                unused_s;

    assign unused_s = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2]};

    mem_lane_unit u_lane (
        .size_i       (d_size),
        .unsigned_i   (d_unsigned),
        .addr_lo_i    (d_addr[1:0]),
        .rdata_i      (mem_rdata),
        .wdata_i      (d_wdata),
        .load_o       (load_s),
        .merge_o      (merge_s),
        .misaligned_o (mis_s)
    );

    // Grant selection, memory drive and next-state for the arbiter FSM
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        mem_addr    = i_addr[ADDR_W+1:2];
        mem_wdata   = d_wdata;
        mem_write   = 1'b0;
        i_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && d_req && (!i_req || last_gnt_q == PORT_I)) begin
                    d_gnt      = 1'b1;
                    last_gnt_d = PORT_D;
                    mem_addr   = d_addr[ADDR_W+1:2];
                    if (mis_s) begin
                        d_rvalid_d = 1'b1;
                        d_err_d    = 1'b1;
                        d_rdata_d  = 32'd0;
                    end else if (!d_we) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = load_s;
                    end else if (d_size == SZ_W) begin
                        mem_write  = 1'b1;
                        mem_wdata  = d_wdata;
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = 32'd0;
                    end else begin
                        rmw_addr_d  = d_addr[ADDR_W+1:2];
                        rmw_wdata_d = merge_s;
                        state_d     = RMW_WR;
                    end
                end else if (rst_n && i_req) begin
                    i_gnt      = 1'b1;
                    last_gnt_d = PORT_I;
                    i_rvalid_d = 1'b1;
                    i_rdata_d  = mem_rdata;
                end else begin
                    state_d = IDLE;
                end
            end
            RMW_WR: begin
                // Write back the merged word; completion is reported next cycle
                mem_addr   = rmw_addr_q;
                mem_wdata  = rmw_wdata_q;
                mem_write  = rst_n;
                state_d    = IDLE;
                d_rvalid_d = 1'b1;
                d_rdata_d  = 32'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, round-robin pointer, RMW buffer and registered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= PORT_D;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= 32'd0;
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= 32'd0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            i_rvalid_q  <= i_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule
